// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD constants, digit validity helper and the per-edge operation type
// used by the up/down BCD counter.
package bcd_updown_counter_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
   localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

   typedef enum logic [2:0] {
      OP_IDLE,
      OP_CLEAR,
      OP_LOAD,
      OP_LOAD_ERR,
      OP_COUNT
   } op_e;

   function automatic logic is_valid_bcd(input logic [BCD_W-1:0] nib);
      return (nib <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: clear > load > count, with wrap at 9/0.
// Non-BCD contents read as 9 going up and as 0 going down, so they self-correct.
module bcd_digit
   import bcd_updown_counter_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cen_i,
   input  logic             up_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [BCD_W-1:0] load_nib_i,
   output logic [BCD_W-1:0] nib_o,
   output logic             at_max_o,
   output logic             at_min_o
);

   logic [BCD_W-1:0] nib_q, nib_d;

   assign at_max_o = !is_valid_bcd(nib_q) || (nib_q == BCD_MAX);
   assign at_min_o = !is_valid_bcd(nib_q) || (nib_q == BCD_MIN);
   assign nib_o    = nib_q;

   always_comb begin
      nib_d = nib_q;
      if (clear_i) begin
         nib_d = BCD_MIN;
      end else if (load_i) begin
         nib_d = load_nib_i;
      end else if (cen_i) begin
         if (up_i) begin
            nib_d = at_max_o ? BCD_MIN : nib_q + 4'd1;
         end else begin
            nib_d = at_min_o ? BCD_MAX : nib_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         nib_q <= BCD_MIN;
      end else begin
         nib_q <= nib_d;
      end
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clear, validated parallel load,
// optional saturation, and registered carry/borrow/load-error pulses.
module bcd_updown_counter
   import bcd_updown_counter_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic                  Clock,
   input  logic                  reset_n,
   input  logic                  En,
   input  logic                  Up,
   input  logic                  Clear,
   input  logic                  Load,
   input  logic [BCD_W*DIGITS-1:0] Load_value,
   output logic [BCD_W*DIGITS-1:0] BCD_out,
   output logic                  Carry_out,
   output logic                  Borrow_out,
   output logic                  Load_err,
   output logic                  Zero_flag,
   output logic                  Max_flag
);

   op_e               op;
   logic              load_ok;
   logic              overflow, underflow, hold_sat;
   logic [DIGITS-1:0] at_max, at_min, digit_cen;
   logic [DIGITS:0]   lower9, lower0;
   logic              carry_q, carry_d;
   logic              borrow_q, borrow_d;
   logic              load_err_q, load_err_d;

   always_comb begin
      load_ok = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         load_ok = load_ok & is_valid_bcd(Load_value[k*BCD_W +: BCD_W]);
      end
   end

   always_comb begin
      op = OP_IDLE;
      if (Clear) begin
         op = OP_CLEAR;
      end else if (Load) begin
         op = load_ok ? OP_LOAD : OP_LOAD_ERR;
      end else if (En) begin
         op = OP_COUNT;
      end
   end

   // lower9[k] / lower0[k]: every digit below k is at 9 / at 0.
   assign lower9[0] = 1'b1;
   assign lower0[0] = 1'b1;

   assign overflow  = (op == OP_COUNT) && Up  && lower9[DIGITS];
   assign underflow = (op == OP_COUNT) && !Up && lower0[DIGITS];
   assign hold_sat  = SATURATE && (overflow || underflow);

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      assign lower9[k+1]  = lower9[k] & at_max[k];
      assign lower0[k+1]  = lower0[k] & at_min[k];
      assign digit_cen[k] = (op == OP_COUNT) && !hold_sat && (Up ? lower9[k] : lower0[k]);

      bcd_digit u_digit (
         .clk_i      (Clock),
         .rst_ni     (reset_n),
         .cen_i      (digit_cen[k]),
         .up_i       (Up),
         .clear_i    (op == OP_CLEAR),
         .load_i     (op == OP_LOAD),
         .load_nib_i (Load_value[k*BCD_W +: BCD_W]),
         .nib_o      (BCD_out[k*BCD_W +: BCD_W]),
         .at_max_o   (at_max[k]),
         .at_min_o   (at_min[k])
      );
   end

   assign carry_d    = overflow;
   assign borrow_d   = underflow;
   assign load_err_d = (op == OP_LOAD_ERR);

   always_ff @(posedge Clock or negedge reset_n) begin
      if (!reset_n) begin
         carry_q    <= 1'b0;
         borrow_q   <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         carry_q    <= carry_d;
         borrow_q   <= borrow_d;
         load_err_q <= load_err_d;
      end
   end

   assign Carry_out  = carry_q;
   assign Borrow_out = borrow_q;
   assign Load_err   = load_err_q;

   // Flags look at the literal digit values, not the self-correcting view.
   always_comb begin
      Max_flag = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         Max_flag = Max_flag & (BCD_out[k*BCD_W +: BCD_W] == BCD_MAX);
      end
   end

   assign Zero_flag = (BCD_out == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: directed scenarios plus a random run against
// an integer-arithmetic model, for a wrapping and a saturating instance.
module tb_bcd_updown_counter;

   localparam int D   = 4;
   localparam int W   = 4 * D;
   localparam int TOP = 9999;

   logic         Clock, reset_n, En, Up, Clear, Load;
   logic [W-1:0] Load_value;
   logic [W-1:0] bcd0, bcd1;
   logic         c0, b0, le0, z0, mx0;
   logic         c1, b1, le1, z1, mx1;
   logic [W+4:0] obs0, obs1;

   int n_cmp  = 0;
   int n_fail = 0;

   assign obs0 = {bcd0, c0, b0, le0, z0, mx0};
   assign obs1 = {bcd1, c1, b1, le1, z1, mx1};

   bcd_updown_counter #(.DIGITS(D), .SATURATE(1'b0)) dut (
      .Clock(Clock), .reset_n(reset_n), .En(En), .Up(Up), .Clear(Clear), .Load(Load),
      .Load_value(Load_value), .BCD_out(bcd0), .Carry_out(c0), .Borrow_out(b0),
      .Load_err(le0), .Zero_flag(z0), .Max_flag(mx0));

   bcd_updown_counter #(.DIGITS(D), .SATURATE(1'b1)) dut_sat (
      .Clock(Clock), .reset_n(reset_n), .En(En), .Up(Up), .Clear(Clear), .Load(Load),
      .Load_value(Load_value), .BCD_out(bcd1), .Carry_out(c1), .Borrow_out(b1),
      .Load_err(le1), .Zero_flag(z1), .Max_flag(mx1));

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // ---------------- reference model (plain integers) ----------------
   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r = '0;
      int           x = v;
      for (int k = 0; k < D; k++) begin
         r[k*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic bit bcd_ok(input logic [W-1:0] b);
      for (int k = 0; k < D; k++) if (b[k*4 +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int from_bcd(input logic [W-1:0] b);
      int v = 0;
      for (int k = D - 1; k >= 0; k--) v = v * 10 + int'(b[k*4 +: 4]);
      return v;
   endfunction

   // Next value and pulses for one edge, from the current inputs.
   task automatic model_edge(input int m, input bit sat, output int nm,
                             output bit ec, output bit eb, output bit ele);
      nm = m; ec = 0; eb = 0; ele = 0;
      if (Clear) nm = 0;
      else if (Load) begin
         if (bcd_ok(Load_value)) nm = from_bcd(Load_value);
         else ele = 1;
      end else if (En) begin
         if (Up) begin
            if (m == TOP) begin ec = 1; nm = sat ? TOP : 0; end
            else nm = m + 1;
         end else begin
            if (m == 0) begin eb = 1; nm = sat ? 0 : TOP; end
            else nm = m - 1;
         end
      end
   endtask

   function automatic logic [W+4:0] expect_vec(input int m, input bit ec, input bit eb, input bit ele);
      return {to_bcd(m), ec, eb, ele, (m == 0), (m == TOP)};
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      En = 0; Up = 0; Clear = 0; Load = 0; Load_value = '0;
   endtask

   task automatic do_load(input logic [W-1:0] v);
      idle(); Load = 1; Load_value = v;
      tick();
      idle();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle();
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (obs0 !== expect_vec(0, 0, 0, 0)) begin
         n_fail++; $display("FAIL reset_async: got %h want %h", obs0, expect_vec(0, 0, 0, 0));
      end
      En = 1; Up = 1;
      tick();
      n_cmp++;
      if (obs1 !== expect_vec(0, 0, 0, 0)) begin
         n_fail++; $display("FAIL reset_hold: got %h want %h", obs1, expect_vec(0, 0, 0, 0));
      end
      reset_n = 1'b1;
      tick();
      n_cmp++;
      if (bcd0 !== 16'h0001) begin
         n_fail++; $display("FAIL reset_first_count: got %h want %h", bcd0, 16'h0001);
      end
      idle(); Clear = 1;
      tick();
      idle();
   endtask

   task automatic test_full_wrap();
      int carries0 = 0, carries1 = 0, edge0 = -1, edge1 = -1;
      idle(); En = 1; Up = 1;
      for (int i = 1; i <= 10000; i++) begin
         tick();
         if (c0) begin carries0++; edge0 = i; end
         if (c1) begin carries1++; edge1 = i; end
      end
      idle();
      n_cmp++;
      if (bcd0 !== 16'h0000 || carries0 != 1 || edge0 != 10000) begin
         n_fail++;
         $display("FAIL wrap_10000: got bcd=%h carries=%0d edge=%0d want 0000/1/10000", bcd0, carries0, edge0);
      end
      n_cmp++;
      if (bcd1 !== 16'h9999 || carries1 != 1 || edge1 != 10000) begin
         n_fail++;
         $display("FAIL sat_10000: got bcd=%h carries=%0d edge=%0d want 9999/1/10000", bcd1, carries1, edge1);
      end
   endtask

   task automatic test_borrow();
      do_load(16'h0000);
      En = 1; Up = 0;
      tick();
      idle();
      n_cmp++;
      if (obs0 !== expect_vec(TOP, 0, 1, 0)) begin
         n_fail++; $display("FAIL borrow_wrap: got %h want %h", obs0, expect_vec(TOP, 0, 1, 0));
      end
      n_cmp++;
      if (obs1 !== expect_vec(0, 0, 1, 0)) begin
         n_fail++; $display("FAIL borrow_sat: got %h want %h", obs1, expect_vec(0, 0, 1, 0));
      end
      tick();
      n_cmp++;
      if (b0 !== 1'b0 || b1 !== 1'b0) begin
         n_fail++; $display("FAIL borrow_one_cycle: got %b%b want 00", b0, b1);
      end
   endtask

   task automatic test_load_err();
      do_load(16'h0057);
      Load = 1; Load_value = 16'h12A4; En = 1; Up = 1;
      tick();
      idle();
      n_cmp++;
      if (obs0 !== expect_vec(57, 0, 0, 1)) begin
         n_fail++; $display("FAIL load_reject: got %h want %h", obs0, expect_vec(57, 0, 0, 1));
      end
      tick();
      n_cmp++;
      if (obs0 !== expect_vec(57, 0, 0, 0)) begin
         n_fail++; $display("FAIL load_err_clear: got %h want %h", obs0, expect_vec(57, 0, 0, 0));
      end
      do_load(16'h1299);
      n_cmp++;
      if (obs0 !== expect_vec(1299, 0, 0, 0)) begin
         n_fail++; $display("FAIL load_accept: got %h want %h", obs0, expect_vec(1299, 0, 0, 0));
      end
   endtask

   task automatic test_priority();
      do_load(16'h9999);
      Clear = 1; Load = 1; Load_value = 16'h5555; En = 1; Up = 1;
      tick();
      idle();
      n_cmp++;
      if (obs0 !== expect_vec(0, 0, 0, 0) || obs1 !== expect_vec(0, 0, 0, 0)) begin
         n_fail++; $display("FAIL clear_priority: got %h/%h want %h", obs0, obs1, expect_vec(0, 0, 0, 0));
      end
   endtask

   task automatic test_ripple();
      do_load(16'h0199);
      En = 1; Up = 1;
      tick();
      n_cmp++;
      if (bcd0 !== 16'h0200) begin
         n_fail++; $display("FAIL ripple_up: got %h want %h", bcd0, 16'h0200);
      end
      Up = 0;
      tick();
      n_cmp++;
      if (bcd0 !== 16'h0199) begin
         n_fail++; $display("FAIL ripple_down: got %h want %h", bcd0, 16'h0199);
      end
      En = 0;
      for (int i = 0; i < 4; i++) begin
         Up = i[0];
         tick();
      end
      n_cmp++;
      if (obs0 !== expect_vec(199, 0, 0, 0)) begin
         n_fail++; $display("FAIL hold_en_low: got %h want %h", obs0, expect_vec(199, 0, 0, 0));
      end
      idle();
   endtask

   task automatic test_async_mid();
      do_load(16'h4321);
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (obs0 !== expect_vec(0, 0, 0, 0) || z0 !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid_cycle: got %h want %h", obs0, expect_vec(0, 0, 0, 0));
      end
      reset_n = 1'b1;
      tick();
      n_cmp++;
      if (obs1 !== expect_vec(0, 0, 0, 0)) begin
         n_fail++; $display("FAIL reset_after_release: got %h want %h", obs1, expect_vec(0, 0, 0, 0));
      end
   endtask

   task automatic test_random();
      int m0 = 0, m1 = 0, nm0, nm1;
      bit ec0, eb0, el0, ec1, eb1, el1;
      int bad = 0;
      idle(); Clear = 1;
      tick();
      for (int i = 0; i < 600; i++) begin
         Clear = ($urandom_range(0, 19) == 0);
         Load  = ($urandom_range(0, 7) == 0);
         En    = ($urandom_range(0, 3) != 0);
         Up    = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 3))
            0:       Load_value = W'($urandom);
            1:       Load_value = ($urandom_range(0, 1) == 1) ? 16'h9998 : 16'h0001;
            default: Load_value = to_bcd($urandom_range(0, TOP));
         endcase
         model_edge(m0, 1'b0, nm0, ec0, eb0, el0);
         model_edge(m1, 1'b1, nm1, ec1, eb1, el1);
         tick();
         m0 = nm0; m1 = nm1;
         n_cmp++;
         if (obs0 !== expect_vec(m0, ec0, eb0, el0)) begin
            n_fail++; bad++;
            if (bad < 10) $display("FAIL random_wrap[%0d]: got %h want %h", i, obs0, expect_vec(m0, ec0, eb0, el0));
         end
         n_cmp++;
         if (obs1 !== expect_vec(m1, ec1, eb1, el1)) begin
            n_fail++; bad++;
            if (bad < 10) $display("FAIL random_sat[%0d]: got %h want %h", i, obs1, expect_vec(m1, ec1, eb1, el1));
         end
      end
      idle();
   endtask

   initial begin
      reset_n = 1'b1;
      idle();
      test_reset();
      test_full_wrap();
      test_borrow();
      test_load_err();
      test_priority();
      test_ripple();
      test_async_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
